// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one registered adder among NREQ requesters
// One operation is outstanding at a time: grant, issue pulse, wait LAT cycles, hold response until taken.
module adder_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 1,
  parameter int IDW   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  output logic                  add_en,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic             add_en_q, add_en_d;
  logic             busy_q, busy_d;

  logic             grant_valid;
  logic [PW-1:0]    grant_idx;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_cin;

  // Lowest valid index above the pointer wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i <= int'(ptr_q))) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i > int'(ptr_q))) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(i);
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_cin   = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == grant_idx) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
      req_ready[i] = reset_n && (state_q == S_IDLE) && grant_valid && (PW'(i) == grant_idx);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    add_en_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          add_a_d   = sel_a;
          add_b_d   = sel_b;
          add_cin_d = sel_cin;
          add_en_d  = 1'b1;
          ptr_d     = grant_idx;
          rsp_id_d  = IDW'(grant_idx);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 3'(LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          rsp_sum_d   = add_sum;
          rsp_cout_d  = add_cout;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= PW'(NREQ - 1);
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      add_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      add_en_q    <= add_en_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign add_en    = add_en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed bench for adder_share_arbiter (LAT=1 and LAT=3 instances)
module tb_adder_share_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // LAT=1 instance signals
  logic [3:0]  req_valid = '0, req_ready, req_cin = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_cout, add_cin, add_en, add_cout, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum, add_a, add_b, add_sum;

  // LAT=3 instance signals
  logic [3:0]  req_valid3 = '0, req_ready3, req_cin3 = '0;
  logic [31:0] req_a3 = '0, req_b3 = '0;
  logic        rsp_valid3, rsp_ready3 = 1'b1, rsp_cout3, add_cin3, add_en3, add_cout3, busy3;
  logic [1:0]  rsp_id3;
  logic [7:0]  rsp_sum3, add_a3, add_b3, add_sum3;

  adder_share_arbiter #(.NREQ(4), .WIDTH(8), .LAT(1), .IDW(2)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_en(add_en),
    .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
  );

  adder_share_arbiter #(.NREQ(4), .WIDTH(8), .LAT(3), .IDW(2)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_a(req_a3), .req_b(req_b3), .req_cin(req_cin3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_sum(rsp_sum3), .rsp_cout(rsp_cout3),
    .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3), .add_en(add_en3),
    .add_sum(add_sum3), .add_cout(add_cout3), .busy(busy3)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Adder models: result presented only in the cycle it is due, otherwise junk.
  logic [8:0] p1;
  logic       v1 = 1'b0;
  logic [8:0] p3 [3];
  logic [2:0] v3 = '0;
  always @(posedge clock) begin
    v1    <= add_en;
    p1    <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    v3    <= {v3[1:0], add_en3};
    p3[0] <= {1'b0, add_a3} + {1'b0, add_b3} + {8'd0, add_cin3};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign add_sum   = v1 ? p1[7:0] : 8'hEE;
  assign add_cout  = v1 ? p1[8] : 1'b1;
  assign add_sum3  = v3[2] ? p3[2][7:0] : 8'hEE;
  assign add_cout3 = v3[2] ? p3[2][8] : 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event logs sampled on the falling edge.
  int hs_id[$], hs_cyc[$], en_cyc[$], rs_id[$], rs_sum[$], rs_cout[$], rs_cyc[$];
  int hs3_cyc[$], en3_cyc[$], rs3_id[$], rs3_sum[$], rs3_cout[$], rs3_cyc[$];
  int onehot_bad = 0;

  always @(negedge clock) begin
    if ($countones(req_ready) > 1) onehot_bad++;
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) begin hs_id.push_back(i); hs_cyc.push_back(cyc); end
    if (add_en) en_cyc.push_back(cyc);
    if (rsp_valid && rsp_ready) begin
      rs_id.push_back(int'(rsp_id)); rs_sum.push_back(int'(rsp_sum));
      rs_cout.push_back(int'(rsp_cout)); rs_cyc.push_back(cyc);
    end
    if (req_valid3[0] && req_ready3[0]) hs3_cyc.push_back(cyc);
    if (add_en3) en3_cyc.push_back(cyc);
    if (rsp_valid3 && rsp_ready3) begin
      rs3_id.push_back(int'(rsp_id3)); rs3_sum.push_back(int'(rsp_sum3));
      rs3_cout.push_back(int'(rsp_cout3)); rs3_cyc.push_back(cyc);
    end
  end

  task automatic drv;
    @(posedge clock); #1;
  endtask

  task automatic smp;
    @(negedge clock); #2;
  endtask

  task automatic clear_logs;
    hs_id.delete(); hs_cyc.delete(); en_cyc.delete();
    rs_id.delete(); rs_sum.delete(); rs_cout.delete(); rs_cyc.delete();
  endtask

  task automatic wait_hs(input int n);
    for (int k = 0; k < 60 && hs_cyc.size() < n; k++) smp();
    chk("hs_timeout", hs_cyc.size(), n);
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 60 && rs_cyc.size() < n; k++) smp();
    chk("rsp_timeout", rs_cyc.size(), n);
  endtask

  task automatic single_op(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
    clear_logs();
    drv();
    req_a = '0; req_b = '0; req_cin = '0;
    req_a[id*8 +: 8] = a; req_b[id*8 +: 8] = b; req_cin[id] = cin;
    req_valid = 4'b0001 << id;
    wait_hs(1);
    drv();
    req_valid = '0;
    wait_rsp(1);
    smp(); smp();
    chk({tag, "_en_count"}, en_cyc.size(), 1);
    if (hs_cyc.size() > 0 && en_cyc.size() > 0 && rs_cyc.size() > 0) begin
      chk({tag, "_en_cycle"}, en_cyc[0] - hs_cyc[0], 1);
      chk({tag, "_rsp_cycle"}, rs_cyc[0] - hs_cyc[0], 3);
      chk({tag, "_id"}, rs_id[0], id);
      chk({tag, "_sum"}, rs_sum[0], exp_sum);
      chk({tag, "_cout"}, rs_cout[0], exp_cout);
    end
  endtask

  logic [7:0] exp_s [4] = '{8'h03, 8'h11, 8'h00, 8'hFF};
  logic       exp_c [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    // Reset with every requester valid: req_ready must stay low, registers zero.
    req_valid = 4'hF;
    req_a = {8'h55, 8'h80, 8'hF0, 8'h01};
    req_b = {8'hAA, 8'h80, 8'h20, 8'h02};
    req_cin = 4'b0010;
    rsp_ready = 1'b1;
    repeat (3) smp();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_sum, rsp_cout}, 0);
    chk("rst_add", {add_a, add_b, add_cin, add_en}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy3", {busy3, rsp_valid3, add_en3}, 0);

    // Test 3: all requesters held valid from reset -> rotation 0,1,2,3,0,1 every 4 cycles.
    clear_logs();
    drv();
    reset_n = 1'b1;
    wait_hs(6);
    drv();
    req_valid = '0;
    wait_rsp(6);
    smp(); smp();
    chk("t3_hs_total", hs_cyc.size(), 6);
    if (hs_cyc.size() == 6 && rs_cyc.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t3_grant", hs_id[k], k % 4);
        if (k > 0) chk("t3_spacing", hs_cyc[k] - hs_cyc[k-1], 4);
        chk("t3_rsp_id", rs_id[k], k % 4);
        chk("t3_sum", rs_sum[k], exp_s[k % 4]);
        chk("t3_cout", rs_cout[k], exp_c[k % 4]);
      end
    end

    // Tests 1 and 2.
    single_op("t1", 1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    single_op("t2", 2, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);

    // Test 4: response back-pressure with requesters 0 and 3 waiting.
    clear_logs();
    drv();
    rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_cin = '0;
    req_a[31:24] = 8'h01; req_b[31:24] = 8'h02;
    req_valid = 4'b1000;
    wait_hs(1);
    drv();
    req_a[7:0] = 8'h11; req_b[7:0] = 8'h22;
    req_valid = 4'b1001;
    for (int k = 0; k < 20 && !rsp_valid; k++) smp();
    for (int k = 0; k < 5; k++) begin
      chk("t4_rsp_valid", rsp_valid, 1);
      chk("t4_rsp_fields", {rsp_id, rsp_sum, rsp_cout}, {2'd3, 8'h03, 1'b0});
      chk("t4_no_ready", req_ready, 0);
      chk("t4_no_en", add_en, 0);
      if (k < 4) smp();
    end
    drv();
    rsp_ready = 1'b1;
    wait_hs(2);
    drv();
    req_valid = '0;
    wait_rsp(2);
    if (hs_cyc.size() == 2 && rs_cyc.size() == 2) begin
      chk("t4_grant_id", hs_id[1], 0);
      chk("t4_grant_after_rsp", hs_cyc[1] - rs_cyc[0], 1);
      chk("t4_req0_sum", rs_sum[1], 8'h33);
    end
    smp(); smp();

    // Test 5: reset during WAIT of a req2 operation.
    clear_logs();
    drv();
    req_a = '0; req_b = '0; req_cin = '0;
    req_a[23:16] = 8'h40; req_b[23:16] = 8'h02;
    req_a[31:24] = 8'h03; req_b[31:24] = 8'h04;
    req_valid = 4'b1100;
    wait_hs(1);
    if (hs_id.size() > 0) chk("t5_first_grant", hs_id[0], 2);
    drv();
    drv();
    reset_n = 1'b0;
    smp();
    chk("t5_busy_in_wait", busy, 1);
    drv();
    reset_n = 1'b1;
    smp();
    chk("t5_post_rst", {rsp_valid, add_en, busy}, 0);
    chk("t5_ready_req2", req_ready, 4'b0100);
    wait_hs(2);
    drv();
    req_valid = '0;
    wait_rsp(1);
    repeat (6) smp();
    chk("t5_rsp_count", rs_cyc.size(), 1);
    if (hs_cyc.size() == 2 && rs_cyc.size() == 1) begin
      chk("t5_regrant", hs_id[1], 2);
      chk("t5_rsp_after_regrant", rs_cyc[0] - hs_cyc[1], 3);
      chk("t5_sum", rs_sum[0], 8'h42);
    end

    // Test 6: LAT=3 instance.
    drv();
    req_a3[7:0] = 8'h10; req_b3[7:0] = 8'h20; req_cin3 = '0;
    req_valid3 = 4'b0001;
    for (int k = 0; k < 30 && hs3_cyc.size() < 1; k++) smp();
    chk("t6_hs", hs3_cyc.size(), 1);
    drv();
    req_valid3 = '0;
    for (int k = 0; k < 30 && rs3_cyc.size() < 1; k++) smp();
    chk("t6_rsp", rs3_cyc.size(), 1);
    smp(); smp();
    chk("t6_en_count", en3_cyc.size(), 1);
    if (hs3_cyc.size() == 1 && rs3_cyc.size() == 1 && en3_cyc.size() == 1) begin
      chk("t6_en_cycle", en3_cyc[0] - hs3_cyc[0], 1);
      chk("t6_rsp_cycle", rs3_cyc[0] - hs3_cyc[0], 5);
      chk("t6_sum", rs3_sum[0], 8'h30);
      chk("t6_cout", rs3_cout[0], 0);
      chk("t6_id", rs3_id[0], 0);
    end

    chk("ready_onehot", onehot_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
